// File: rtl/xmodem_rx_ctrl.sv
// xmodem_rx_ctrl
// XMODEM receive controller. Turns the UART receive byte stream into scene
// memory byte writes and answers each block with ACK/NAK, aborting with a
// double CAN when the sender misbehaves or retries run out. Handles 128-byte
// SOH blocks, optional 1024-byte STX blocks, 8-bit checksum or CRC-16/XMODEM,
// duplicate-block suppression, an inter-byte timeout and bounded retries.
//
// Ports:
//   clk, rst                   sole clock, synchronous active-high reset
//   start                      one-cycle pulse, begins a transfer from IDLE
//   rx_data, rx_valid          received byte and its one-cycle strobe
//   tx_data, tx_valid, tx_ready response byte, held until tx_valid & tx_ready
//   wr_en, wr_addr, wr_data    single-byte memory write, one cycle after rx
//   bytes_loaded               total bytes of ACKed blocks
//   done, error                sticky: EOT acknowledged / transfer aborted
module xmodem_rx_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int ENABLE_1K   = 1,
  parameter int CRC_MODE    = 0,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int MAX_RETRIES = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [ADDR_W:0]   bytes_loaded,
  output logic              done,
  output logic              error
);

  localparam logic [7:0] SOH = 8'h01;
  localparam logic [7:0] STX = 8'h02;
  localparam logic [7:0] EOT = 8'h04;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam logic [7:0] CAN = 8'h18;
  localparam logic [7:0] START_CHR = (CRC_MODE != 0) ? 8'h43 : NAK;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam int RTY_W = $clog2(MAX_RETRIES + 2);
  localparam int BL_W  = ADDR_W + 1;

  typedef enum logic [3:0] {
    IDLE, INIT, WAIT_HDR, BLK, BLK_N, DATA, CHK_HI, CHK_LO, RESP, DONE, ABORT
  } state_t;

  typedef enum logic [1:0] {RK_PLAIN, RK_NEW, RK_EOT} resp_t;

  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  state_t            state, state_n;
  resp_t             resp_kind, resp_kind_n;
  logic              tx_valid_n, done_n, error_n;
  logic [7:0]        tx_data_n;
  logic              vld_p1, vld_n;
  logic [ADDR_W-1:0] wr_addr_p1, wr_addr_n;
  logic [7:0]        wr_data_p1, wr_data_n;
  logic [BL_W-1:0]   bl_n;
  logic [7:0]        expected, expected_n;
  logic [ADDR_W-1:0] base, base_n;
  logic [RTY_W-1:0]  retries, retries_n, retries_inc;
  logic [TMO_W-1:0]  tmo_cnt, tmo_n;
  logic              first_hdr, first_hdr_n;
  logic              can_second, can_second_n;
  logic              len_1k, len_1k_n;
  logic [7:0]        blk, blk_n;
  logic              bad, bad_n, dup, dup_n;
  logic [9:0]        idx, idx_n, idx_last;
  logic [10:0]       len_val;
  logic [7:0]        sum, sum_n, chk_hi, chk_hi_n;
  logic [15:0]       crc, crc_n;
  logic              tx_fire, counting, tmo_hit, rty_over, chk_ok;
  logic              retry_evt, abort_evt;
  logic [7:0]        retry_chr;
  state_t            retry_to;

  assign tx_fire     = tx_valid & tx_ready;
  assign counting    = state inside {WAIT_HDR, BLK, BLK_N, DATA, CHK_HI, CHK_LO};
  assign tmo_hit     = counting && !rx_valid && (tmo_cnt == TMO_LAST);
  assign retries_inc = retries + 1'b1;
  assign rty_over    = (int'(retries_inc) > MAX_RETRIES);
  assign idx_last    = len_1k ? 10'd1023 : 10'd127;
  assign len_val     = len_1k ? 11'd1024 : 11'd128;
  assign chk_ok      = (CRC_MODE != 0) ? ({chk_hi, rx_data} == crc) : (rx_data == sum);

  // Stage p0: byte decode, next-state and response selection
  always_comb begin
    state_n      = state;
    resp_kind_n  = resp_kind;
    tx_valid_n   = tx_valid;
    tx_data_n    = tx_data;
    vld_n        = 1'b0;
    wr_addr_n    = wr_addr_p1;
    wr_data_n    = wr_data_p1;
    bl_n         = bytes_loaded;
    done_n       = done;
    error_n      = error;
    expected_n   = expected;
    base_n       = base;
    retries_n    = retries;
    first_hdr_n  = first_hdr;
    can_second_n = can_second;
    len_1k_n     = len_1k;
    blk_n        = blk;
    bad_n        = bad;
    dup_n        = dup;
    idx_n        = idx;
    sum_n        = sum;
    crc_n        = crc;
    chk_hi_n     = chk_hi;
    tmo_n        = '0;
    retry_evt    = 1'b0;
    abort_evt    = 1'b0;
    retry_chr    = NAK;
    retry_to     = RESP;

    if (counting && !rx_valid && !tmo_hit) tmo_n = tmo_cnt + 1'b1;

    case (state)
      IDLE: begin
        if (start) begin
          tx_valid_n  = 1'b1;
          tx_data_n   = START_CHR;
          expected_n  = 8'd1;
          base_n      = '0;
          bl_n        = '0;
          retries_n   = '0;
          first_hdr_n = 1'b0;
          state_n     = INIT;
        end
      end
      INIT: begin
        if (tx_fire) begin
          tx_valid_n = 1'b0;
          state_n    = WAIT_HDR;
        end
      end
      WAIT_HDR: begin
        if (rx_valid) begin
          case (rx_data)
            SOH: begin
              len_1k_n    = 1'b0;
              first_hdr_n = 1'b1;
              state_n     = BLK;
            end
            STX: begin
              if (ENABLE_1K != 0) begin
                len_1k_n    = 1'b1;
                first_hdr_n = 1'b1;
                state_n     = BLK;
              end
            end
            EOT: begin
              tx_valid_n  = 1'b1;
              tx_data_n   = ACK;
              resp_kind_n = RK_EOT;
              state_n     = RESP;
            end
            default: ;
          endcase
        end else if (tmo_hit) begin
          retry_evt = 1'b1;
          if (!first_hdr) begin
            retry_chr = START_CHR;
            retry_to  = INIT;
          end
        end
      end
      BLK: begin
        if (rx_valid) begin
          blk_n   = rx_data;
          state_n = BLK_N;
        end else if (tmo_hit) begin
          retry_evt = 1'b1;
        end
      end
      BLK_N: begin
        if (rx_valid) begin
          bad_n = (rx_data != ~blk);
          dup_n = (blk == expected - 8'd1);
          idx_n = '0;
          sum_n = '0;
          crc_n = '0;
          // Only a trustworthy block number can be a sequence error.
          if ((rx_data == ~blk) && (blk != expected) && (blk != expected - 8'd1))
            abort_evt = 1'b1;
          else
            state_n = DATA;
        end else if (tmo_hit) begin
          retry_evt = 1'b1;
        end
      end
      DATA: begin
        if (rx_valid) begin
          if (!bad && !dup) begin
            vld_n     = 1'b1;
            wr_addr_n = base + ADDR_W'(idx);
            wr_data_n = rx_data;
          end
          sum_n = sum + rx_data;
          crc_n = crc16_upd(crc, rx_data);
          idx_n = idx + 10'd1;
          if (idx == idx_last) state_n = (CRC_MODE != 0) ? CHK_HI : CHK_LO;
        end else if (tmo_hit) begin
          retry_evt = 1'b1;
        end
      end
      CHK_HI: begin
        if (rx_valid) begin
          chk_hi_n = rx_data;
          state_n  = CHK_LO;
        end else if (tmo_hit) begin
          retry_evt = 1'b1;
        end
      end
      CHK_LO: begin
        if (rx_valid) begin
          if (chk_ok && !bad) begin
            tx_valid_n  = 1'b1;
            tx_data_n   = ACK;
            resp_kind_n = dup ? RK_PLAIN : RK_NEW;
            state_n     = RESP;
          end else begin
            retry_evt = 1'b1;
          end
        end else if (tmo_hit) begin
          retry_evt = 1'b1;
        end
      end
      RESP: begin
        if (tx_fire) begin
          tx_valid_n = 1'b0;
          case (resp_kind)
            RK_NEW: begin
              base_n     = base + ADDR_W'(len_val);
              bl_n       = bytes_loaded + BL_W'(len_val);
              expected_n = expected + 8'd1;
              retries_n  = '0;
              state_n    = WAIT_HDR;
            end
            RK_EOT: begin
              done_n  = 1'b1;
              state_n = DONE;
            end
            default: state_n = WAIT_HDR;
          endcase
        end
      end
      ABORT: begin
        if (tx_fire) begin
          if (!can_second) begin
            can_second_n = 1'b1;
          end else begin
            tx_valid_n = 1'b0;
            error_n    = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (abort_evt || (retry_evt && rty_over)) begin
      state_n      = ABORT;
      tx_valid_n   = 1'b1;
      tx_data_n    = CAN;
      can_second_n = 1'b0;
    end else if (retry_evt) begin
      retries_n   = retries_inc;
      state_n     = retry_to;
      tx_valid_n  = 1'b1;
      tx_data_n   = retry_chr;
      resp_kind_n = RK_PLAIN;
    end
  end

  // Stage p1: registered control, response and write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      resp_kind    <= RK_PLAIN;
      tx_valid     <= 1'b0;
      tx_data      <= '0;
      vld_p1       <= 1'b0;
      wr_addr_p1   <= '0;
      wr_data_p1   <= '0;
      bytes_loaded <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      expected     <= 8'd1;
      base         <= '0;
      retries      <= '0;
      tmo_cnt      <= '0;
      first_hdr    <= 1'b0;
      can_second   <= 1'b0;
    end else begin
      state        <= state_n;
      resp_kind    <= resp_kind_n;
      tx_valid     <= tx_valid_n;
      tx_data      <= tx_data_n;
      vld_p1       <= vld_n;
      wr_addr_p1   <= wr_addr_n;
      wr_data_p1   <= wr_data_n;
      bytes_loaded <= bl_n;
      done         <= done_n;
      error        <= error_n;
      expected     <= expected_n;
      base         <= base_n;
      retries      <= retries_n;
      tmo_cnt      <= tmo_n;
      first_hdr    <= first_hdr_n;
      can_second   <= can_second_n;
    end
  end

  always_ff @(posedge clk) begin
    len_1k <= len_1k_n;
    blk    <= blk_n;
    bad    <= bad_n;
    dup    <= dup_n;
    idx    <= idx_n;
    sum    <= sum_n;
    crc    <= crc_n;
    chk_hi <= chk_hi_n;
  end

  assign wr_en   = vld_p1;
  assign wr_addr = wr_addr_p1;
  assign wr_data = wr_data_p1;

endmodule
